// File: rtl/fc_scheduler.sv
// fc_scheduler: buffers feature triplets, sequences one FC run at a time, and emits argmax/margin results
module fc_scheduler #(
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_in0,
    input  logic [DATA_W-1:0] s_in1,
    input  logic [DATA_W-1:0] s_in2,
    output logic              fc_valid_in,
    output logic [DATA_W-1:0] fc_in0,
    output logic [DATA_W-1:0] fc_in1,
    output logic [DATA_W-1:0] fc_in2,
    input  logic [DATA_W-1:0] fc_data_out,
    input  logic              fc_valid_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_score0,
    output logic [DATA_W-1:0] m_score1,
    output logic              m_class,
    output logic [DATA_W:0]   m_margin,
    output logic              err_timeout,
    output logic              busy,
    output logic [15:0]       frame_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT0, WAIT1, OUT} state_t;

    state_t state_q, state_d;
    logic [3*DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [DATA_W-1:0] in0_q, in0_d, in1_q, in1_d, in2_q, in2_d;
    logic [DATA_W-1:0] sc0_q, sc0_d, sc1_q, sc1_d;
    logic cls_q, cls_d;
    logic [DATA_W:0] mar_q, mar_d;
    logic [15:0] frame_q, frame_d;
    logic push, pop, waiting, tmo;

    assign s_ready     = cnt_q != CW'(FIFO_DEPTH);
    assign push        = s_valid && s_ready;
    assign pop         = state_q == IDLE && cnt_q != '0;
    assign waiting     = state_q == WAIT0 || state_q == WAIT1;
    assign tmo         = waiting && !fc_valid_out && tmr_q == TW'(TIMEOUT - 1);
    assign fc_valid_in = state_q == ISSUE;
    assign fc_in0      = in0_q;
    assign fc_in1      = in1_q;
    assign fc_in2      = in2_q;
    assign m_valid     = state_q == OUT;
    assign m_score0    = sc0_q;
    assign m_score1    = sc1_q;
    assign m_class     = cls_q;
    assign m_margin    = mar_q;
    assign err_timeout = tmo;
    assign busy        = state_q != IDLE || cnt_q != '0;
    assign frame_cnt   = frame_q;

    // Triplet storage; contents need no reset since pointers gate every read
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {s_in2, s_in1, s_in0};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Frame sequencing: issue, count the two score beats, hold result until accepted
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        in0_d   = in0_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        sc0_d   = sc0_q;
        sc1_d   = sc1_q;
        cls_d   = cls_q;
        mar_d   = mar_q;
        frame_d = frame_q;
        case (state_q)
            IDLE: if (pop) begin
                {in2_d, in1_d, in0_d} = mem_q[rd_q];
                state_d = ISSUE;
            end
            ISSUE: begin
                tmr_d   = '0;
                state_d = WAIT0;
            end
            WAIT0: begin
                tmr_d = tmr_q + TW'(1);
                if (fc_valid_out) begin
                    sc0_d   = fc_data_out;
                    state_d = WAIT1;
                end else if (tmo) state_d = IDLE;
            end
            WAIT1: begin
                tmr_d = tmr_q + TW'(1);
                if (fc_valid_out) begin
                    sc1_d   = fc_data_out;
                    cls_d   = $signed(fc_data_out) > $signed(sc0_q);
                    mar_d   = {fc_data_out[DATA_W-1], fc_data_out} - {sc0_q[DATA_W-1], sc0_q};
                    state_d = OUT;
                end else if (tmo) state_d = IDLE;
            end
            OUT: if (m_ready) begin
                frame_d = frame_q + 16'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            in0_q   <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            sc0_q   <= '0;
            sc1_q   <= '0;
            cls_q   <= 1'b0;
            mar_q   <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            sc0_q   <= sc0_d;
            sc1_q   <= sc1_d;
            cls_q   <= cls_d;
            mar_q   <= mar_d;
            frame_q <= frame_d;
        end
    end
endmodule

// File: tb/tb_fc_scheduler.sv
// tb_fc_scheduler: randomized and directed checks of fc_scheduler against a frame-level queue model
module tb_fc_scheduler;
    localparam int DW = 12;
    localparam int TO = 15;

    typedef struct {
        int a, b, c, s0, s1, d0, g;
        bit to;
    } frame_t;
    typedef struct {
        int c;
        int d;
    } beat_t;

    logic clk = 1'b0, rst = 1'b0;
    logic s_valid = 1'b0, s_ready;
    logic [DW-1:0] s_in0 = '0, s_in1 = '0, s_in2 = '0;
    logic fc_valid_in;
    logic [DW-1:0] fc_in0, fc_in1, fc_in2;
    logic [DW-1:0] fc_data_out = '0;
    logic fc_valid_out = 1'b0;
    logic m_valid, m_ready = 1'b0;
    logic [DW-1:0] m_score0, m_score1;
    logic m_class;
    logic [DW:0] m_margin;
    logic err_timeout, busy;
    logic [15:0] frame_cnt;

    fc_scheduler #(.DATA_W(DW), .FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_in0(s_in0), .s_in1(s_in1), .s_in2(s_in2),
        .fc_valid_in(fc_valid_in),
        .fc_in0(fc_in0), .fc_in1(fc_in1), .fc_in2(fc_in2),
        .fc_data_out(fc_data_out), .fc_valid_out(fc_valid_out),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_score0(m_score0), .m_score1(m_score1),
        .m_class(m_class), .m_margin(m_margin),
        .err_timeout(err_timeout), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0, iss_cyc = 0, issues = 0, pushed = 0, acc = 0, frames = 0, errs = 0;
    bit in_flight = 0, rnd_on = 0;
    frame_t pl, cur;
    frame_t exp_q[$];
    beat_t beat_q[$];

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    // FC model: plays back the scheduled score beats in their cycles
    always @(posedge clk) begin
        beat_t bt;
        cyc++;
        #1;
        fc_valid_out = 1'b0;
        while (beat_q.size() != 0 && beat_q[0].c < cyc) bt = beat_q.pop_front();
        if (beat_q.size() != 0 && beat_q[0].c == cyc) begin
            bt = beat_q.pop_front();
            fc_valid_out = 1'b1;
            fc_data_out  = DW'(bt.d);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_on) m_ready = $urandom_range(0, 3) != 0;
    end

    // Frame-level reference: every accepted triplet issues once, in order, and yields its planned scores
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            in_flight = 0;
            frames = 0;
        end else begin
            if (err_timeout) errs++;
            if (s_valid && s_ready) begin
                exp_q.push_back(pl);
                pushed++;
            end
            if (fc_valid_in) begin
                chk("one_in_flight", int'(in_flight), 0);
                if (exp_q.size() == 0) chk("issue_empty", int'(fc_valid_in), 0);
                else begin
                    cur = exp_q.pop_front();
                    chk("fc_in0", $signed(fc_in0), cur.a);
                    chk("fc_in1", $signed(fc_in1), cur.b);
                    chk("fc_in2", $signed(fc_in2), cur.c);
                    in_flight = 1;
                    iss_cyc = cyc;
                    issues++;
                    beat_q.push_back('{cyc + cur.d0, cur.s0});
                    if (!cur.to) beat_q.push_back('{cyc + cur.d0 + cur.g, cur.s1});
                end
            end
            if (in_flight && cur.to && cyc == iss_cyc + TO) begin
                chk("timeout_pulse", int'(err_timeout), 1);
                in_flight = 0;
            end else if (err_timeout) chk("timeout_stray", int'(err_timeout), 0);
            if (m_valid) begin
                if (!in_flight || cur.to) chk("m_valid_stray", int'(m_valid), 0);
                else if (m_ready) begin
                    chk("score0", $signed(m_score0), cur.s0);
                    chk("score1", $signed(m_score1), cur.s1);
                    chk("class", int'(m_class), int'(cur.s1 > cur.s0));
                    chk("margin", $signed(m_margin), cur.s1 - cur.s0);
                    chk("frame_cnt", int'(frame_cnt), frames);
                    frames++;
                    acc++;
                    in_flight = 0;
                end
            end
        end
    end

    task automatic push(input int a, b, c, s0, s1, d0, g, input bit to);
        pl = '{a, b, c, s0, s1, d0, g, to};
        s_in0 = DW'(a);
        s_in1 = DW'(b);
        s_in2 = DW'(c);
        s_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (s_ready) break;
        end
        if (!s_ready) chk("push_stall", int'(s_ready), 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int n);
        for (int t = 0; t < 3000 && acc < n; t++) @(negedge clk);
        chk("results", acc, n);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_fc_valid_in", int'(fc_valid_in), 0);
        chk("rst_fc_in", int'({fc_in0, fc_in1, fc_in2}), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_scores", int'({m_score0, m_score1}), 0);
        chk("rst_class", int'(m_class), 0);
        chk("rst_margin", int'(m_margin), 0);
        chk("rst_err", int'(err_timeout), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
    endtask

    initial begin
        int base, i0, e0, n;
        bit to;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        m_ready = 1'b1;
        push(10, 20, -5, -3, 7, 2, 1, 0);
        wait_done(1);
        chk("single_frame_cnt", int'(frame_cnt), 1);
        chk("single_issues", issues, 1);

        push(1, 2, 3, 5, 5, 2, 1, 0);
        push(4, 5, 6, 100, -100, 2, 1, 0);
        wait_done(3);

        m_ready = 1'b0;
        base = pushed;
        i0 = issues;
        fork
            for (int i = 0; i < 6; i++) push(i * 7 - 20, i, -i, i * 50 - 100, 90 - i * 40, 2, 1, 0);
            begin
                repeat (14) @(negedge clk);
                chk("bp_s_ready", int'(s_ready), 0);
                chk("bp_pushed", pushed - base, 5);
                chk("bp_issues", issues - i0, 1);
                @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        join
        wait_done(9);
        chk("bp_frame_cnt", int'(frame_cnt), 9);

        e0 = errs;
        push(7, 8, 9, 11, 22, 2, 1, 1);
        push(-7, -8, -9, -30, -40, 2, 1, 0);
        wait_done(10);
        chk("timeout_count", errs - e0, 1);

        i0 = issues;
        beat_q.push_back('{cyc + 2, 123});
        repeat (6) @(negedge clk);
        chk("stray_busy", int'(busy), 0);
        chk("stray_m_valid", int'(m_valid), 0);
        chk("stray_issues", issues - i0, 0);
        @(posedge clk);
        #1;
        push(3, 3, 3, -1, 1, 1, 1, 0);
        wait_done(11);

        rnd_on = 1'b1;
        n = acc;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            to = $urandom_range(0, 7) == 0;
            if (!to) n++;
            push(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                 int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                 int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(1, 3)),
                 int'($urandom_range(1, 3)), to);
        end
        wait_done(n);
        rnd_on = 1'b0;
        #2;
        m_ready = 1'b0;

        i0 = issues;
        push(1, 1, 1, 10, 20, 2, 3, 0);
        push(2, 2, 2, 10, 20, 2, 1, 0);
        push(3, 3, 3, 10, 20, 2, 1, 0);
        for (int t = 0; t < 50 && !in_flight; t++) @(negedge clk);
        chk("rst_test_issued", issues - i0, 1);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < iss_cyc + 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset();
        i0 = issues;
        repeat (10) @(negedge clk);
        chk("rst_no_issue", issues - i0, 0);
        chk("rst_idle_busy", int'(busy), 0);
        chk("rst_no_m_valid", int'(m_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
